// File: rtl/mtc_link_arbiter.sv
// mtc_link_arbiter: filters NUM_IN MTC candidate streams for words addressed
// to this link (LINK_SLCID/LINK_SLID), buffers one matched word per input and
// serialises them onto one SL output through a round-robin arbiter with a
// valid/ready handshake.
// Optional build macro MTC_LINK_MULTI_MATCH_ERR_EN adds a sticky flag that
// reports two or more inputs matching in the same cycle.
module mtc_link_arbiter #(
  parameter int LINK_SLID  = 0,
  parameter int LINK_SLCID = 0,
  parameter int NUM_IN     = 3,
  parameter int DATA_W     = 193,
  parameter int VALID_BIT  = 192,
  parameter int SLCID_LSB  = 157,
  parameter int SLID_LSB   = 93,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] mtc_in [NUM_IN-1:0],
  output logic [DATA_W-1:0] mtc2sl,
  output logic              mtc2sl_valid,
  input  logic              mtc2sl_ready,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              multi_match_err
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PC_W  = $clog2(NUM_IN + 1);

  // Number of set bits in an event vector.
  function automatic logic [PC_W-1:0] popcount(input logic [NUM_IN-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_IN; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [PC_W-1:0]  inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [NUM_IN-1:0] match;
  logic [NUM_IN-1:0] pend_vld;
  logic [DATA_W-1:0] pend_data [NUM_IN-1:0];
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] load_ev;
  logic [NUM_IN-1:0] drop_ev;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              out_free;

  // ---- stage p0: address filter and per-input pending buffer
  // Word is ours when valid and both the SLC ID and SL ID fields match.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_IN; i++)
      match[i] = mtc_in[i][VALID_BIT] &&
                 (mtc_in[i][SLCID_LSB +: 3] == 3'(LINK_SLCID)) &&
                 (mtc_in[i][SLID_LSB +: 6] == 6'(LINK_SLID));
  end

  // A slot being granted this edge can take a new word; otherwise a full slot drops it.
  assign load_ev = match & (~pend_vld | grant);
  assign drop_ev = match & pend_vld & ~grant;

  // Pending slots: load on accepted match, release on grant.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pend_vld <= '0;
      for (int i = 0; i < NUM_IN; i++) pend_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (load_ev[i]) begin
          pend_data[i] <= mtc_in[i];
          pend_vld[i]  <= 1'b1;
        end else if (grant[i]) begin
          pend_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // Saturating status counters, stepped by the number of events per cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      match_cnt <= sat_add(match_cnt, popcount(load_ev));
      drop_cnt  <= sat_add(drop_cnt, popcount(drop_ev));
    end
  end

  // ---- stage p1: round-robin arbitration into the output register
  assign out_free = !mtc2sl_valid || mtc2sl_ready;

  // Search begins one past the last winner and wraps, so every input gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (out_free) begin
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!gnt_any && pend_vld[PTR_W'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  // Output register: held while stalled, refilled or emptied when free.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mtc2sl       <= '0;
      mtc2sl_valid <= 1'b0;
      rr_ptr       <= '0;
    end else if (out_free) begin
      if (gnt_any) begin
        mtc2sl       <= pend_data[gnt_idx];
        mtc2sl_valid <= 1'b1;
        rr_ptr       <= gnt_idx;
      end else begin
        mtc2sl       <= '0;
        mtc2sl_valid <= 1'b0;
      end
    end
  end

`ifdef MTC_LINK_MULTI_MATCH_ERR_EN
  // Sticky flag: two or more inputs addressed this link in the same cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                               multi_match_err <= 1'b0;
    else if (popcount(match) > PC_W'(1))   multi_match_err <= 1'b1;
  end
`else
  assign multi_match_err = 1'b0;
`endif

endmodule
